// File: rtl/wave_dac_spi.sv
// wave_dac_spi: waveform select, power-of-two attenuation, offset-binary
// conversion and 16-bit SPI frame serializer for a 12-bit DAC.
// Strobes that arrive while a frame is in flight are dropped and counted.
module wave_dac_spi #(
    parameter int         DW     = 12,
    parameter int         CLKDIV = 4,
    parameter logic [3:0] CMD    = 4'b0011
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [DW-1:0] sin_in,
    input  logic [DW-1:0] cos_in,
    input  logic [DW-1:0] tri_in,
    input  logic [DW-1:0] sqr_in,
    input  logic [1:0]    wave_sel,
    input  logic [2:0]    gain_shift,
    input  logic          sample_stb,
    output logic          dac_sclk,
    output logic          dac_cs_n,
    output logic          dac_mosi,
    output logic          busy,
    output logic          overrun,
    output logic [7:0]    overrun_cnt
);

    localparam int FW = DW + 4;
    localparam int CW = $clog2(2 * CLKDIV + 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLKDIV - 1);
    localparam logic [CW-1:0] FULL_END = CW'(2 * CLKDIV - 1);
    localparam logic [4:0]    LAST_BIT = 5'(FW - 1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    state_t               state;
    logic [CW-1:0]        cnt;
    logic [4:0]           bit_cnt;
    // Holds the bits still to be sent after the one currently on dac_mosi.
    logic [FW-2:0]        sr;
    logic signed [DW-1:0] sel;
    logic signed [DW-1:0] shifted;
    logic [DW-1:0]        code;
    logic [FW-1:0]        frame;

    // Pick the waveform named by wave_sel.
    always_comb begin
        sel = sin_in;
        case (wave_sel)
            2'b00:   sel = sin_in;
            2'b01:   sel = cos_in;
            2'b10:   sel = tri_in;
            default: sel = sqr_in;
        endcase
    end

    // Arithmetic shift floors toward -inf; flipping the MSB turns two's
    // complement into offset binary (0x800 -> 0x000, 0x7FF -> 0xFFF).
    assign shifted = sel >>> gain_shift;
    assign code    = {~shifted[DW-1], shifted[DW-2:0]};
    assign frame   = {CMD, code};
    assign busy    = (state != IDLE);

    // Frame sequencer: SETUP (CS low, MSB presented), SHIFT (16 sclk periods,
    // mosi updated on each falling edge), HOLD (CS high), back to IDLE.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_cnt  <= '0;
            sr       <= '0;
            dac_sclk <= 1'b0;
            dac_cs_n <= 1'b1;
            dac_mosi <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cnt     <= '0;
                    bit_cnt <= '0;
                    if (sample_stb) begin
                        sr       <= frame[FW-2:0];
                        dac_mosi <= frame[FW-1];
                        dac_cs_n <= 1'b0;
                        dac_sclk <= 1'b0;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt == HALF_END) begin
                        cnt      <= '0;
                        dac_sclk <= 1'b1;
                        state    <= SHIFT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (cnt == FULL_END) begin
                        cnt <= '0;
                        if (bit_cnt == LAST_BIT) begin
                            dac_cs_n <= 1'b1;
                            state    <= HOLD;
                        end else begin
                            bit_cnt  <= bit_cnt + 5'd1;
                            dac_sclk <= 1'b1;
                        end
                    end else begin
                        // Falling edge: present the next bit (zero after the last).
                        if (cnt == HALF_END) begin
                            dac_sclk <= 1'b0;
                            dac_mosi <= sr[FW-2];
                            sr       <= {sr[FW-3:0], 1'b0};
                        end
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    if (cnt == HALF_END) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // Dropped-strobe pulse and saturating counter; cleared only by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            overrun     <= 1'b0;
            overrun_cnt <= '0;
        end else begin
            overrun <= sample_stb && busy;
            if (sample_stb && busy && overrun_cnt != 8'hFF)
                overrun_cnt <= overrun_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_wave_dac_spi.sv
// tb_wave_dac_spi: randomized and directed checks of wave_dac_spi against a
// frame-level reference model (floor division + offset, expected timings).
module tb_wave_dac_spi;

    logic        clock = 1'b0;
    logic        reset;
    logic [11:0] sin_in, cos_in, tri_in, sqr_in;
    logic [1:0]  wave_sel;
    logic [2:0]  gain_shift;
    logic        stb0, stb1;
    logic        sclk0, csn0, mosi0, busy0, ovr0;
    logic        sclk1, csn1, mosi1, busy1, ovr1;
    logic [7:0]  ocnt0, ocnt1;
    int          passed = 0;
    int          total  = 0;

    always #5 clock = ~clock;

    wave_dac_spi #(.DW(12), .CLKDIV(4), .CMD(4'b0011)) dut (
        .clock(clock), .reset(reset), .sin_in(sin_in), .cos_in(cos_in),
        .tri_in(tri_in), .sqr_in(sqr_in), .wave_sel(wave_sel),
        .gain_shift(gain_shift), .sample_stb(stb0), .dac_sclk(sclk0),
        .dac_cs_n(csn0), .dac_mosi(mosi0), .busy(busy0), .overrun(ovr0),
        .overrun_cnt(ocnt0));

    wave_dac_spi #(.DW(12), .CLKDIV(1), .CMD(4'b0011)) dut1 (
        .clock(clock), .reset(reset), .sin_in(sin_in), .cos_in(cos_in),
        .tri_in(tri_in), .sqr_in(sqr_in), .wave_sel(wave_sel),
        .gain_shift(gain_shift), .sample_stb(stb1), .dac_sclk(sclk1),
        .dac_cs_n(csn1), .dac_mosi(mosi1), .busy(busy1), .overrun(ovr1),
        .overrun_cnt(ocnt1));

    // Reference: floor(v / 2^g), then +2048 gives offset binary, CMD on top.
    function automatic logic [15:0] ref_frame(input logic [11:0] x, input int g);
        int v, d, fl;
        v  = int'($signed(x));
        d  = 1 << g;
        fl = (v >= 0) ? v / d : -((-v + d - 1) / d);
        return 16'(32'h3000 + fl + 2048);
    endfunction

    function automatic logic [11:0] pick(input logic [1:0] ws, input logic [11:0] s, c, t, q);
        return (ws == 2'd0) ? s : (ws == 2'd1) ? c : (ws == 2'd2) ? t : q;
    endfunction

    task automatic set_stb(input int u, input logic v);
        if (u != 0) stb1 = v; else stb0 = v;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    // Issue one strobe (entered and left on a negedge), follow the frame and
    // report the bits seen on sclk rises plus busy / cs_n-low / overrun cycles.
    // extra_at: frame cycle (1 = first busy cycle) in which to pulse a second strobe.
    task automatic run_frame(input int u, input logic [11:0] s, c, t, q,
                             input logic [1:0] ws, input logic [2:0] gs, input int extra_at,
                             output logic [15:0] got, output int nbits, output int busy_n,
                             output int csl_n, output int ovr_n);
        int   cd;
        logic prev;
        cd = (u != 0) ? 1 : 4;
        sin_in = s; cos_in = c; tri_in = t; sqr_in = q;
        wave_sel = ws; gain_shift = gs;
        set_stb(u, 1'b1);
        got = '0; nbits = 0; busy_n = 0; csl_n = 0; ovr_n = 0; prev = 1'b0;
        for (int cyc = 1; cyc <= 40 * cd + 10; cyc++) begin
            @(negedge clock);
            set_stb(u, cyc == extra_at);
            sin_in = 12'($urandom); cos_in = 12'($urandom);
            tri_in = 12'($urandom); sqr_in = 12'($urandom);
            wave_sel = 2'($urandom); gain_shift = 3'($urandom);
            if ((u != 0) ? ovr1 : ovr0) ovr_n++;
            if (!((u != 0) ? busy1 : busy0)) break;
            busy_n++;
            if (!((u != 0) ? csn1 : csn0)) csl_n++;
            if (((u != 0) ? sclk1 : sclk0) && !prev) begin
                got = {got[14:0], ((u != 0) ? mosi1 : mosi0)};
                nbits++;
            end
            prev = (u != 0) ? sclk1 : sclk0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; stb0 = 1'b0; stb1 = 1'b0;
        sin_in = '0; cos_in = '0; tri_in = '0; sqr_in = '0; wave_sel = '0; gain_shift = '0;
        @(negedge clock);
        total++; if (sclk0 !== 1'b0) $display("FAIL reset_sclk got %b want 0", sclk0); else passed++;
        total++; if (csn0 !== 1'b1) $display("FAIL reset_cs_n got %b want 1", csn0); else passed++;
        total++; if (mosi0 !== 1'b0) $display("FAIL reset_mosi got %b want 0", mosi0); else passed++;
        total++; if ({busy0, busy1} !== 2'b00) $display("FAIL reset_busy got %b want 00", {busy0, busy1}); else passed++;
        total++; if (ovr0 !== 1'b0) $display("FAIL reset_overrun got %b want 0", ovr0); else passed++;
        total++; if ({ocnt0, ocnt1} !== 16'h0) $display("FAIL reset_ovr_cnt got %h want 0000", {ocnt0, ocnt1}); else passed++;
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_basic();
        logic [15:0] got; int nb, bn, cl, ov;
        run_frame(0, 12'h7FF, 12'h000, 12'h000, 12'h000, 2'b00, 3'd0, -1, got, nb, bn, cl, ov);
        total++; if (got !== 16'h3FFF) $display("FAIL basic_frame got %h want 3fff", got); else passed++;
        total++; if (nb != 16) $display("FAIL basic_nbits got %0d want 16", nb); else passed++;
        total++; if (bn != 136) $display("FAIL basic_busy got %0d want 136", bn); else passed++;
        total++; if (cl != 132) $display("FAIL basic_cs_low got %0d want 132", cl); else passed++;
        total++; if (ov != 0) $display("FAIL basic_overrun got %0d want 0", ov); else passed++;
    endtask

    task automatic test_codes();
        logic [1:0]  ws [3] = '{2'd2, 2'd1, 2'd3};
        logic [11:0] val[3] = '{12'h800, 12'h000, 12'h800};
        logic [2:0]  gs [3] = '{3'd0, 3'd0, 3'd2};
        logic [15:0] ex [3] = '{16'h3000, 16'h3800, 16'h3600};
        logic [15:0] got; int nb, bn, cl, ov;
        for (int i = 0; i < 3; i++) begin
            run_frame(0, (ws[i] == 2'd0) ? val[i] : 12'h123, (ws[i] == 2'd1) ? val[i] : 12'h456,
                      (ws[i] == 2'd2) ? val[i] : 12'h789, (ws[i] == 2'd3) ? val[i] : 12'hABC,
                      ws[i], gs[i], -1, got, nb, bn, cl, ov);
            total++; if (got !== ex[i]) $display("FAIL code_%0d got %h want %h", i, got, ex[i]); else passed++;
            total++; if (bn != 136) $display("FAIL code_busy_%0d got %0d want 136", i, bn); else passed++;
        end
    endtask

    task automatic test_random();
        logic [15:0] got, exp; int nb, bn, cl, ov;
        logic [11:0] s, c, t, q; logic [1:0] ws; logic [2:0] gs;
        for (int i = 0; i < 10; i++) begin
            s = 12'($urandom); c = 12'($urandom); t = 12'($urandom); q = 12'($urandom);
            ws = 2'($urandom); gs = 3'($urandom);
            if (i == 0) begin ws = 2'd3; q = 12'h800; gs = 3'd7; end
            exp = ref_frame(pick(ws, s, c, t, q), int'(gs));
            if (i == 0 && exp !== 16'h37F0) $display("FAIL model_edge got %h want 37f0", exp);
            run_frame(0, s, c, t, q, ws, gs, -1, got, nb, bn, cl, ov);
            total++; if (got !== exp) $display("FAIL rand_%0d sel=%0d g=%0d got %h want %h", i, ws, gs, got, exp); else passed++;
            total++; if (nb != 16 || bn != 136) $display("FAIL rand_len_%0d got %0d/%0d want 16/136", i, nb, bn); else passed++;
        end
    endtask

    task automatic test_overrun();
        logic [15:0] got; int nb, bn, cl, ov, late;
        do_reset();
        run_frame(0, 12'h3A5, 12'h000, 12'h000, 12'h000, 2'b00, 3'd1, 50, got, nb, bn, cl, ov);
        total++; if (got !== ref_frame(12'h3A5, 1)) $display("FAIL ovr_frame got %h want %h", got, ref_frame(12'h3A5, 1)); else passed++;
        total++; if (bn != 136) $display("FAIL ovr_busy got %0d want 136", bn); else passed++;
        total++; if (ov != 1) $display("FAIL ovr_pulse got %0d want 1", ov); else passed++;
        total++; if (ocnt0 !== 8'd1) $display("FAIL ovr_cnt got %0d want 1", ocnt0); else passed++;
        late = 0;
        for (int i = 0; i < 6; i++) begin
            if (busy0) late++;
            @(negedge clock);
        end
        total++; if (late != 0) $display("FAIL ovr_no_second got %0d busy cycles want 0", late); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [15:0] got; int nb, bn, cl, ov;
        run_frame(0, 12'h000, 12'h000, 12'hC01, 12'h000, 2'b10, 3'd3, 136, got, nb, bn, cl, ov);
        total++; if (got !== ref_frame(12'hC01, 3)) $display("FAIL hold_frame got %h want %h", got, ref_frame(12'hC01, 3)); else passed++;
        total++; if (ov != 1) $display("FAIL hold_pulse got %0d want 1", ov); else passed++;
        total++; if (ocnt0 !== 8'd2) $display("FAIL hold_cnt got %0d want 2", ocnt0); else passed++;
        run_frame(0, 12'h000, 12'h5F0, 12'h000, 12'h000, 2'b01, 3'd0, -1, got, nb, bn, cl, ov);
        total++; if (bn != 136) $display("FAIL b2b_busy got %0d want 136", bn); else passed++;
        total++; if (got !== 16'h3DF0) $display("FAIL b2b_frame got %h want 3df0", got); else passed++;
    endtask

    task automatic test_reset_mid();
        logic [15:0] got; int nb, bn, cl, ov;
        sin_in = 12'h123; wave_sel = 2'b00; gain_shift = 3'd0; stb0 = 1'b1;
        @(negedge clock);
        stb0 = 1'b0;
        repeat (62) @(negedge clock);
        total++; if (csn0 !== 1'b0) $display("FAIL mid_pre_cs_n got %b want 0", csn0); else passed++;
        reset = 1'b1;
        #1;
        total++; if (csn0 !== 1'b1) $display("FAIL mid_cs_n got %b want 1", csn0); else passed++;
        total++; if (sclk0 !== 1'b0) $display("FAIL mid_sclk got %b want 0", sclk0); else passed++;
        total++; if (busy0 !== 1'b0) $display("FAIL mid_busy got %b want 0", busy0); else passed++;
        total++; if (ocnt0 !== 8'd0) $display("FAIL mid_cnt got %0d want 0", ocnt0); else passed++;
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        run_frame(0, 12'h9C4, 12'h000, 12'h000, 12'h000, 2'b00, 3'd0, -1, got, nb, bn, cl, ov);
        total++; if (got !== 16'h31C4) $display("FAIL mid_after got %h want 31c4", got); else passed++;
        total++; if (bn != 136) $display("FAIL mid_after_busy got %0d want 136", bn); else passed++;
    endtask

    task automatic test_saturate();
        int left, drops, waited;
        do_reset();
        left = 0; drops = 0;
        stb0 = 1'b1;
        for (int c = 0; c < 300; c++) begin
            if (c == 200) begin
                total++; if (ocnt0 !== 8'(drops)) $display("FAIL sat_mid got %0d want %0d", ocnt0, drops); else passed++;
            end
            if (left > 0) begin drops++; left--; end
            else left = 136;
            @(negedge clock);
        end
        stb0 = 1'b0;
        total++; if (ocnt0 !== 8'd255 || drops < 255) $display("FAIL sat_cnt got %0d want 255 (drops %0d)", ocnt0, drops); else passed++;
        waited = 0;
        while (busy0 && waited < 200) begin @(negedge clock); waited++; end
        total++; if (busy0 !== 1'b0) $display("FAIL sat_idle got %b want 0", busy0); else passed++;
        total++; if (ocnt0 !== 8'd255) $display("FAIL sat_hold got %0d want 255", ocnt0); else passed++;
    endtask

    task automatic test_clkdiv1();
        logic [15:0] got; int nb, bn, cl, ov;
        run_frame(1, 12'h7FF, 12'h000, 12'h000, 12'h000, 2'b00, 3'd0, -1, got, nb, bn, cl, ov);
        total++; if (got !== 16'h3FFF) $display("FAIL div1_frame got %h want 3fff", got); else passed++;
        total++; if (nb != 16) $display("FAIL div1_nbits got %0d want 16", nb); else passed++;
        total++; if (bn != 34) $display("FAIL div1_busy got %0d want 34", bn); else passed++;
        total++; if (cl != 33) $display("FAIL div1_cs_low got %0d want 33", cl); else passed++;
        total++; if (ocnt1 !== 8'd0) $display("FAIL div1_cnt got %0d want 0", ocnt1); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_codes();
        test_random();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        test_saturate();
        test_clkdiv1();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d at timeout", passed, total);
        $fatal(1);
    end

endmodule

// File: doc/wave_dac_spi.md
Name: wave_dac_spi

Overview:
Downstream stage of the 12-bit CORDIC waveform generator. It takes the four registered waveform outputs (sine, cosine, triangle, square) and selects one. It applies a power-of-two attenuation and converts the value from two's complement to offset binary. It then serializes a 16-bit command+data frame to an external 12-bit SPI DAC, and flags samples that arrive while a frame is still in flight.

Parameters:
DW, 12, waveform sample width (signed two's complement).
CLKDIV, 4, SCLK half-period in clock cycles (minimum 1).
CMD, 4'b0011, control nibble sent ahead of the data (write-and-update).

Ports:
clock  input  1  system clock, all logic on rising edge.
reset  input  1  asynchronous, active-high reset.
sin_in  input  DW  signed sine sample.
cos_in  input  DW  signed cosine sample.
tri_in  input  DW  signed triangle sample.
sqr_in  input  DW  signed square sample.
wave_sel  input  2  00 sin, 01 cos, 10 tri, 11 sqr.
gain_shift  input  3  arithmetic right-shift amount (0..7).
sample_stb  input  1  one-cycle pulse: inputs valid, request a frame.
dac_sclk  output  1  SPI clock; idles low; DAC samples on the rising edge.
dac_cs_n  output  1  SPI chip select, active low.
dac_mosi  output  1  serial data, MSB first.
busy  output  1  high whenever the FSM is not in IDLE.
overrun  output  1  one-cycle pulse when a strobe is dropped.
overrun_cnt  output  8  saturating count of dropped strobes.

Behaviour:
- Reset values (async, immediate even mid-frame): dac_sclk=0, dac_cs_n=1, dac_mosi=0, busy=0, overrun=0, overrun_cnt=0, FSM=IDLE, shift register=0. Any frame in progress is abandoned; no partial completion.
- FSM states: IDLE, SETUP, SHIFT, HOLD.
- IDLE, sample_stb=1 (cycle 0):
  - Capture the input selected by wave_sel, sampling wave_sel and gain_shift in the same cycle.
  - Arithmetic shift right by gain_shift with sign extension.
  - Form code = shifted value with MSB inverted (offset binary).
  - Load shift reg = {CMD, code}.
  - Go to SETUP.
- SETUP: from cycle 1, dac_cs_n=0, dac_mosi=bit15, dac_sclk=0. Lasts CLKDIV cycles, then go to SHIFT.
- SHIFT: 16 bits, each bit taking 2*CLKDIV cycles.
  - dac_sclk is high for the first CLKDIV cycles of the bit, low for the second CLKDIV.
  - dac_mosi changes only coincident with the sclk falling edge, presenting the next bit.
  - A 5-bit bit counter runs 0..15; after the 16th falling edge, go to HOLD.
  - dac_mosi = 0 after the last bit.
- HOLD: dac_cs_n=1, dac_sclk=0 for CLKDIV cycles, then go to IDLE.
- Frame length: busy is high in cycles 1..34*CLKDIV inclusive (136 cycles at CLKDIV=4). The next strobe is accepted in the first cycle busy=0.
- Strobe while busy=1, including the last HOLD cycle:
  - Sample is dropped and the frame in flight is unaffected.
  - overrun pulses high the following cycle.
  - overrun_cnt increments and saturates at 255; it is cleared only by reset.
- Inputs are not used outside the capture cycle; changes during a frame are ignored.
- Shift edge cases: gain_shift=7 on -2048 gives -16 (0xFF0), so code 0x7F0. Positive values shift toward 0, negative values toward -1 (no rounding).

Test Plan:
1. sin_in=0x7FF, wave_sel=00, gain_shift=0, strobe -> frame 0x3FFF on mosi (16 bits, MSB first, sampled on sclk rise); cs_n low for 33*CLKDIV cycles; busy high for exactly 136 cycles.
2. Code-mapping sweep, gain_shift=0 unless noted, each followed by a strobe:
   - tri_in=0x800 -> frame 0x3000.
   - cos_in=0x000 -> frame 0x3800.
   - sqr_in=0x800 with gain_shift=2 -> frame 0x3600.
3. Second strobe 50 cycles into a frame -> first frame completes unchanged; overrun pulses one cycle; overrun_cnt=1; no second frame starts.
4. Strobe in the last HOLD cycle -> dropped, overrun_cnt increments. Strobe one cycle later (busy=0) -> new frame starts, SETUP begins next cycle.
5. Assert reset during bit 7 of SHIFT -> same cycle dac_cs_n=1, dac_sclk=0, busy=0. After release, a new strobe produces a complete, correct frame.
6. Issue 300 strobes every clock while busy -> overrun_cnt saturates at 255 and does not wrap. Repeat case 1 with CLKDIV=1 -> 34-cycle frame, identical bit sequence.
